// File: rtl/alu_cmd_pipe.sv
// Command FIFO feeding an external combinational ALU, with a registered
// valid/ready result stage on the ALU's Y and flag outputs.
module alu_cmd_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_sel,
  input  logic             in_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             cin;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             in_cmd;
  cmd_t             head;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [3:0]       out_flags_q, out_flags_d;

  logic             push;
  logic             cap;
  logic             not_empty;

  assign in_cmd    = '{a: in_a, b: in_b, sel: in_sel, cin: in_cin};
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  // The head is consumed whenever the output register is free or being drained.
  assign cap       = not_empty && (!out_valid_q || out_ready);

  // Storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_cmd;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign alu_a   = not_empty ? head.a   : '0;
  assign alu_b   = not_empty ? head.b   : '0;
  assign alu_sel = not_empty ? head.sel : '0;
  assign alu_cin = not_empty ? head.cin : 1'b0;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_flags_d = out_flags_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (cap) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push && !cap) begin
      count_d = count_q + CW'(1);
    end else if (!push && cap) begin
      count_d = count_q - CW'(1);
    end

    if (cap) begin
      out_valid_d = 1'b1;
      out_y_d     = alu_y;
      out_flags_d = {alu_cout, alu_neg, alu_zero, alu_ovf};
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_flags_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_flags = out_flags_q;
  assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_pipe.sv
// Bench for alu_cmd_pipe: a small ALU drives the result inputs, a queue model
// of the FIFO and result register is compared every cycle, plus literal checks.
module tb_alu_cmd_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic [3:0]        in_sel = '0;
  logic              in_cin = 1'b0;
  logic [WIDTH-1:0]  alu_a, alu_b;
  logic [3:0]        alu_sel;
  logic              alu_cin;
  logic [WIDTH-1:0]  alu_y;
  logic              alu_cout, alu_neg, alu_zero, alu_ovf;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_y;
  logic [3:0]        out_flags;
  logic [CW-1:0]     count;

  int checks = 0;
  int errors = 0;
  int max_cnt = 0;
  int cyc = 0;

  alu_cmd_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_cin(in_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags), .count(count)
  );

  always #5 clk = ~clk;

  // Reference ALU: AND, OR, ADD, NAND, XOR; flags {Cout, Neg, Zero, Ovf}.
  function automatic void alu_calc(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] sel, input logic cin,
                                   output logic [31:0] y, output logic [3:0] fl);
    logic [32:0] s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    y = '0;
    case (sel)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        y = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      4'b0101: y = ~(a & b);
      4'b0110: y = a ^ b;
      default: y = '0;
    endcase
    fl = {c, y[31], (y == 32'h0), v};
  endfunction

  always_comb begin : b_alu
    logic [31:0] y;
    logic [3:0]  f;
    alu_calc(alu_a, alu_b, alu_sel, alu_cin, y, f);
    alu_y = y;
    {alu_cout, alu_neg, alu_zero, alu_ovf} = f;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: pending commands in a queue, one held result.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
  } cmd_s;

  cmd_s        mq[$];
  logic        m_ov = 1'b0;
  logic [31:0] m_y = '0;
  logic [3:0]  m_fl = '0;

  always @(posedge clk or posedge rst) begin : b_model
    bit   pu, ca;
    cmd_s c;
    if (rst) begin
      mq.delete();
      m_ov = 1'b0;
      m_y  = '0;
      m_fl = '0;
    end else begin
      pu = in_valid && (mq.size() < DEPTH);
      ca = (mq.size() > 0) && (!m_ov || out_ready);
      if (ca) begin
        alu_calc(mq[0].a, mq[0].b, mq[0].sel, mq[0].cin, m_y, m_fl);
        m_ov = 1'b1;
        void'(mq.pop_front());
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (pu) begin
        c.a = in_a; c.b = in_b; c.sel = in_sel; c.cin = in_cin;
        mq.push_back(c);
      end
    end
  end

  always @(negedge clk) begin : b_chk
    logic [31:0] ea, eb;
    logic [3:0]  es;
    logic        ec;
    ea = '0; eb = '0; es = '0; ec = 1'b0;
    if (mq.size() > 0) begin
      ea = mq[0].a; eb = mq[0].b; es = mq[0].sel; ec = mq[0].cin;
    end
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_y", 64'(out_y), 64'(m_y));
    chk("out_flags", 64'(out_flags), 64'(m_fl));
    chk("count", 64'(count), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    chk("alu_a", 64'(alu_a), 64'(ea));
    chk("alu_b", 64'(alu_b), 64'(eb));
    chk("alu_sel", 64'(alu_sel), 64'(es));
    chk("alu_cin", 64'(alu_cin), 64'(ec));
    if (int'(count) > max_cnt) max_cnt = int'(count);
  end

  logic [31:0] got[$];
  int          gcyc[$];

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back(out_y);
      gcyc.push_back(cyc);
    end
    cyc++;
  end

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] sel, input logic cin);
    int n;
    bit ok;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel; in_cin = cin;
    do begin
      ok = in_ready;
      @(negedge clk);
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=not_accepted required=accepted a=%0h", a);
    end
    in_valid = 1'b0;
  endtask

  task automatic single_cmd(input string tag);
    out_ready = 1'b1;
    got.delete();
    push(32'h0000_00FF, 32'h0000_0F0F, 4'b0000, 1'b0);
    chk({tag, "_count_after_push"}, 64'(count), 64'd1);
    chk({tag, "_valid_before"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"}, 64'(out_y), 64'h0000_000F);
    chk({tag, "_flags"}, 64'(out_flags), 64'h0);
    chk({tag, "_count_zero"}, 64'(count), 64'd0);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_emitted"}, 64'(got.size()), 64'd1);
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_y", 64'(out_y), 64'd0);
    chk("reset_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    single_cmd("single");

    // Head drive while the result register is stalled.
    out_ready = 1'b0;
    push(32'h11, 32'h22, 4'b0000, 1'b0);
    @(negedge clk);
    push(32'h1234_5678, 32'h0000_0001, 4'b0010, 1'b1);
    chk("head_count", 64'(count), 64'd1);
    chk("head_alu_a", 64'(alu_a), 64'h1234_5678);
    chk("head_alu_b", 64'(alu_b), 64'h1);
    chk("head_alu_sel", 64'(alu_sel), 64'h2);
    chk("head_alu_cin", 64'(alu_cin), 64'h1);
    chk("head_alu_y", 64'(alu_y), 64'h1234_567A);
    chk("head_held_y", 64'(out_y), 64'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("head_add_y", 64'(out_y), 64'h1234_567A);
    chk("head_empty_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);
    chk("head_drained", 64'(out_valid), 64'd0);

    // Fill under back-pressure.
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 5; i++) begin
      push(32'(i), 32'h0, 4'b0001, 1'b0);
      if (i == 4) begin
        chk("fill_count_4", 64'(count), 64'd3);
        chk("fill_ready_4", 64'(in_ready), 64'd1);
      end
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(in_ready), 64'd0);
    chk("fill_held", 64'(out_y), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("fill_drained", 64'(out_valid), 64'd0);
    chk("fill_n", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk("fill_order", 64'(got[i]), 64'(i + 1));

    // Streaming through several pointer wraps.
    got.delete();
    gcyc.delete();
    max_cnt = 0;
    for (int i = 1; i <= 12; i++) push(32'(i), 32'h0, 4'b0001, 1'b0);
    repeat (3) @(negedge clk);
    chk("stream_n", 64'(got.size()), 64'd12);
    for (int i = 0; i < got.size() && i < 12; i++) begin
      chk("stream_order", 64'(got[i]), 64'(i + 1));
      if (i > 0) chk("stream_rate", 64'(gcyc[i] - gcyc[i-1]), 64'd1);
    end
    chk("stream_max_count_le1", 64'(max_cnt <= 1), 64'd1);

    // Flag capture.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0101, 1'b0);
    @(negedge clk);
    chk("nand_valid", 64'(out_valid), 64'd1);
    chk("nand_y", 64'(out_y), 64'd0);
    chk("nand_flags", 64'(out_flags), 64'b0010);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), 32'h0, 4'b0001, 1'b0);
    chk("rstmid_count_pre", 64'(count), 64'd3);
    chk("rstmid_valid_pre", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_count", 64'(count), 64'd0);
    chk("rstmid_y", 64'(out_y), 64'd0);
    chk("rstmid_flags", 64'(out_flags), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    got.delete();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_no_stale", 64'(got.size()), 64'd0);
    chk("rstmid_idle", 64'(out_valid), 64'd0);

    single_cmd("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_cmd_pipe.md
Name: alu_cmd_pipe

Overview:
- Buffered command/result stage around the combinational 32-bit ALU.
- Queues ALU commands (A, B, sel, Cin) in a small FIFO and drives the head command onto the ALU operand inputs.
- Registers the ALU's Y and flags into an output holding register with a valid/ready handshake.
- Decouples the issuing controller from the result consumer; the ALU itself stays purely combinational between this block's alu_* outputs and alu_* inputs.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- CW, 3, width of the count output; equals log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept; equals (count != DEPTH).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sel  input  4  ALU function select.
- in_cin  input  1  carry in.
- alu_a  output  WIDTH  head-entry A to the ALU.
- alu_b  output  WIDTH  head-entry B to the ALU.
- alu_sel  output  4  head-entry sel to the ALU.
- alu_cin  output  1  head-entry Cin to the ALU.
- alu_y  input  WIDTH  ALU result.
- alu_cout  input  1  ALU Cout.
- alu_neg  input  1  ALU Negative.
- alu_zero  input  1  ALU Zero.
- alu_ovf  input  1  ALU Overflow.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_y  output  WIDTH  registered result.
- out_flags  output  4  registered {Cout, Negative, Zero, Overflow}, MSB first.
- count  output  CW  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_y=0, out_flags=0.
  - FIFO storage is not cleared.
  - Reset mid-operation discards all queued commands and any held result; nothing is emitted after reset releases.
- Push: occurs on a clock edge when in_valid && in_ready. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap).
- Head drive (combinational):
  - When count>0, alu_a/alu_b/alu_sel/alu_cin = entry[rd_ptr].
  - When count==0, all alu_* outputs are 0.
- Capture condition: cap = (count>0) && (!out_valid || out_ready).
  - On an edge with cap: out_y<=alu_y, out_flags<={alu_cout,alu_neg,alu_zero,alu_ovf}, out_valid<=1, and rd_ptr increments modulo DEPTH (pop).
  - On an edge with out_valid && out_ready && !cap: out_valid<=0. out_y/out_flags hold their last values.
  - Otherwise the output register holds.
- Latency: a command pushed at edge k into an empty FIFO, with a free output register, appears with out_valid=1 after edge k+1. Throughput is 1 result/cycle under continuous out_ready.
- Simultaneous push and pop: count is unchanged. Both pointers advance.
- Full (count==DEPTH): in_ready=0.
  - The upstream side must hold the command.
  - No bypass: a pop in the same cycle does not raise in_ready until the next cycle.
- Empty: no capture occurs. out_valid falls once the held result is accepted.
- Back-pressure: while out_valid && !out_ready, the output register is frozen. The FIFO keeps accepting commands until full.
- Ordering: results leave in strict push order. No command is dropped or duplicated.
- in_* values while in_valid=0 are ignored.

Test Plan:
- Single command: reset, push A=0x0000_00FF, B=0x0000_0F0F, sel=0000 (AND), Cin=0; hold out_ready=1.
  - Required: out_valid=1 exactly one cycle after the push edge.
  - out_y=0x0000_000F, out_flags=0000.
  - count returns to 0.
- Head drive: push while out_valid=1 and out_ready=0 so the entry stays queued.
  - Required: alu_a/alu_b/alu_sel/alu_cin equal the pushed values.
  - When count==0, alu_a=0.
- Fill and back-pressure: out_ready=0; push 5 commands with A=1..5, B=0, sel=0001 (OR).
  - Required: in_ready drops after the 4th FIFO entry.
  - count=4 with one result held, i.e. 5 accepted in total.
  - Release out_ready: outputs 1,2,3,4,5 appear in order, then out_valid=0.
- Streaming and wrap: out_ready=1; push 12 consecutive OR commands with A=i, B=0.
  - Required: out_y=i in order, 1 per cycle after the first.
  - count never exceeds 1; the pointers wrap 3 times without loss.
- Flag capture: command sel=0101 (NAND), A=B=0xFFFF_FFFF.
  - Required: out_y=0, out_flags Zero bit=1.
  - The registered flags must equal the ALU flag values sampled on the capture edge.
- Reset mid-operation: 3 commands queued and out_valid=1; assert rst asynchronously between edges.
  - Required: out_valid, count and out_y are 0 immediately.
  - After release, no stale result appears; a new push behaves as in the first scenario.
